// File: rtl/mgia_pkg.sv
// Shared constants and types for the MGIA video fetch/shift path.
package mgia_pkg;
   localparam int WORDS_PER_LINE = 40;
   localparam int DOTS_PER_WORD  = 16;
   localparam int BUF_IDX_W      = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/mgia_line_buffer.sv
// Ping-pong line buffer: two banks of 64 x 16-bit words, one write port and
// one synchronous read port with a single cycle of read latency.
module mgia_line_buffer
   import mgia_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [BUF_IDX_W:0]   i_waddr,
   input  logic [15:0]          i_wdata,
   input  logic [BUF_IDX_W:0]   i_raddr,
   output logic [15:0]          o_rdata
);
   logic [15:0] r_mem [0:(2**(BUF_IDX_W+1))-1];
   logic [15:0] r_rdata;

   // Storage array and registered read; contents are not reset, stale words are shown as-is.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/mgia_fetch_shifter.sv
// MGIA fetch and pixel shift stage: fetches one scan line over Wishbone into a
// ping-pong buffer and shifts the previous line out MSB-first as 1 bpp video.
module mgia_fetch_shifter
   import mgia_pkg::*;
#(
   parameter int AW = 23
) (
   input  logic          CLK_I,
   input  logic          RST_I_N,
   input  logic          HSYNC_I,
   input  logic          VSYNC_I,
   input  logic          VFEN_I,
   input  logic          VREN_I,
   input  logic          ODD_I,
   input  logic [AW-1:0] FB_BASE_I,
   output logic          CYC_O,
   output logic          STB_O,
   output logic [AW-1:0] ADR_O,
   input  logic          ACK_I,
   input  logic [15:0]   DAT_I,
   output logic          VIDEO_O,
   output logic          HSYNC_O,
   output logic          VSYNC_O,
   output logic          UNDERRUN_O
);
   localparam logic [AW-1:0]        LINE_STEP   = AW'(WORDS_PER_LINE);
   localparam logic [BUF_IDX_W-1:0] LAST_WORD   = BUF_IDX_W'(WORDS_PER_LINE - 1);
   localparam logic [3:0]           PREFETCH_BC = 4'(DOTS_PER_WORD - 2);

   fetch_state_t         r_state;
   logic                 r_vfen_q;
   logic                 r_vsync_q;
   logic [AW-1:0]        r_frame_base;
   logic [AW-1:0]        r_line_off;
   logic [AW-1:0]        r_adr;
   logic                 r_cyc;
   logic                 r_underrun;
   logic [BUF_IDX_W-1:0] r_wc;
   logic [BUF_IDX_W-1:0] r_ri;
   logic [3:0]           r_bc;
   logic [15:0]          r_shift;
   logic                 r_vren_d1;
   logic                 r_video;
   logic                 r_hs_d1;
   logic                 r_hs_d2;
   logic                 r_vs_d1;
   logic                 r_vs_d2;

   logic                 w_vfen_rise;
   logic                 w_vfen_fall;
   logic                 w_vsync_rise;
   logic [AW-1:0]        w_line_base;
   logic                 w_buf_we;
   logic [BUF_IDX_W:0]   w_waddr;
   logic [BUF_IDX_W:0]   w_raddr;
   logic [15:0]          w_rd_data;

   assign w_vfen_rise  = VFEN_I & ~r_vfen_q;
   assign w_vfen_fall  = ~VFEN_I & r_vfen_q;
   assign w_vsync_rise = VSYNC_I & ~r_vsync_q;
   // A VSYNC edge coinciding with the fetch start must already use the new base.
   assign w_line_base  = w_vsync_rise ? FB_BASE_I : (r_frame_base + r_line_off);
   assign w_buf_we     = (r_state == READ) & VFEN_I & ACK_I;
   assign w_waddr      = {ODD_I, r_wc};
   assign w_raddr      = {~ODD_I, r_ri};

   mgia_line_buffer u_line_buffer (
      .i_clk   (CLK_I),
      .i_we    (w_buf_we),
      .i_waddr (w_waddr),
      .i_wdata (DAT_I),
      .i_raddr (w_raddr),
      .o_rdata (w_rd_data)
   );

   // Edge detectors and frame/line base bookkeeping.
   always_ff @(posedge CLK_I or negedge RST_I_N) begin
      if (!RST_I_N) begin
         r_vfen_q     <= 1'b0;
         r_vsync_q    <= 1'b0;
         r_frame_base <= '0;
         r_line_off   <= '0;
      end else begin
         r_vfen_q  <= VFEN_I;
         r_vsync_q <= VSYNC_I;
         if (w_vsync_rise) begin
            r_frame_base <= FB_BASE_I;
            r_line_off   <= '0;
         end else if (w_vfen_fall) begin
            r_line_off <= r_line_off + LINE_STEP;
         end
      end
   end

   // Fetch FSM with registered bus outputs.
   always_ff @(posedge CLK_I or negedge RST_I_N) begin
      if (!RST_I_N) begin
         r_state    <= IDLE;
         r_cyc      <= 1'b0;
         r_adr      <= '0;
         r_wc       <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_vfen_rise) begin
                  r_state <= READ;
                  r_adr   <= w_line_base;
                  r_wc    <= '0;
                  r_cyc   <= 1'b1;
               end
            end
            READ: begin
               if (!VFEN_I) begin
                  r_state    <= IDLE;
                  r_cyc      <= 1'b0;
                  r_underrun <= 1'b1;
               end else if (ACK_I) begin
                  r_adr <= r_adr + AW'(1'b1);
                  r_wc  <= r_wc + BUF_IDX_W'(1'b1);
                  if (r_wc == LAST_WORD) begin
                     r_cyc   <= 1'b0;
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               if (!VFEN_I) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cyc   <= 1'b0;
            end
         endcase
      end
   end

   // Pixel shifter; word index idles at 0 so word 0 is already read when the window opens.
   always_ff @(posedge CLK_I or negedge RST_I_N) begin
      if (!RST_I_N) begin
         r_ri      <= '0;
         r_bc      <= 4'd0;
         r_shift   <= 16'd0;
         r_vren_d1 <= 1'b0;
         r_video   <= 1'b0;
      end else begin
         r_vren_d1 <= VREN_I;
         r_video   <= r_shift[15] & r_vren_d1;
         if (VREN_I) begin
            r_bc <= r_bc + 4'd1;
            if (r_bc == PREFETCH_BC) begin
               r_ri <= r_ri + BUF_IDX_W'(1'b1);
            end
            if (r_bc == 4'd0) begin
               r_shift <= w_rd_data;
            end else begin
               r_shift <= {r_shift[14:0], 1'b0};
            end
         end else begin
            r_bc    <= 4'd0;
            r_ri    <= '0;
            r_shift <= 16'd0;
         end
      end
   end

   // Sync delay line matching the two-stage pixel pipeline.
   always_ff @(posedge CLK_I or negedge RST_I_N) begin
      if (!RST_I_N) begin
         r_hs_d1 <= 1'b0;
         r_hs_d2 <= 1'b0;
         r_vs_d1 <= 1'b0;
         r_vs_d2 <= 1'b0;
      end else begin
         r_hs_d1 <= HSYNC_I;
         r_hs_d2 <= r_hs_d1;
         r_vs_d1 <= VSYNC_I;
         r_vs_d2 <= r_vs_d1;
      end
   end

   assign CYC_O      = r_cyc;
   assign STB_O      = r_cyc;
   assign ADR_O      = r_adr;
   assign VIDEO_O    = r_video;
   assign HSYNC_O    = r_hs_d2;
   assign VSYNC_O    = r_vs_d2;
   assign UNDERRUN_O = r_underrun;
endmodule

// File: tb/tb_mgia_fetch_shifter.sv
// Randomized self-checking bench for mgia_fetch_shifter with a line-level
// reference model of the framebuffer, line buffer banks and video output.
module tb_mgia_fetch_shifter;
   localparam int AW       = 23;
   localparam int WPL      = 40;
   localparam int LINE_LEN = 720;
   localparam int N_LINES  = 12;

   typedef struct {
      bit            fetch;
      bit            vis;
      int            wt;
      bit            vs_start;
      bit            vs_blank;
      bit            rst;
      logic [AW-1:0] fb;
   } line_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          hsync_i, vsync_i, vfen_i, vren_i, odd_i;
   logic [AW-1:0] fb_base_i;
   logic          cyc_o, stb_o;
   logic [AW-1:0] adr_o;
   logic          ack_i;
   logic [15:0]   dat_i;
   logic          video_o, hsync_o, vsync_o, underrun_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0]   fb_mem [0:16383];
   logic [15:0]   bank_m [2][WPL];
   bit            bank_v [2][WPL];
   logic [15:0]   disp_w [WPL];
   bit            disp_v [WPL];
   logic [AW-1:0] m_base;
   line_t         lines [N_LINES];

   always #20 clk = ~clk;

   mgia_fetch_shifter #(.AW(AW)) dut (
      .CLK_I      (clk),
      .RST_I_N    (rst_n),
      .HSYNC_I    (hsync_i),
      .VSYNC_I    (vsync_i),
      .VFEN_I     (vfen_i),
      .VREN_I     (vren_i),
      .ODD_I      (odd_i),
      .FB_BASE_I  (fb_base_i),
      .CYC_O      (cyc_o),
      .STB_O      (stb_o),
      .ADR_O      (adr_o),
      .ACK_I      (ack_i),
      .DAT_I      (dat_i),
      .VIDEO_O    (video_o),
      .HSYNC_O    (hsync_o),
      .VSYNC_O    (vsync_o),
      .UNDERRUN_O (underrun_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic line_t mk(bit f, bit v, int w, bit vss, bit vsb, bit r, logic [AW-1:0] fb);
      line_t t;
      t.fetch = f; t.vis = v; t.wt = w; t.vs_start = vss; t.vs_blank = vsb; t.rst = r; t.fb = fb;
      return t;
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_cyc"}, cyc_o, 1'b0);
      check_val({pfx, "_stb"}, stb_o, 1'b0);
      check_val({pfx, "_adr"}, adr_o, 32'd0);
      check_val({pfx, "_video"}, video_o, 1'b0);
      check_val({pfx, "_hsync"}, hsync_o, 1'b0);
      check_val({pfx, "_vsync"}, vsync_o, 1'b0);
      check_val({pfx, "_underrun"}, underrun_o, 1'b0);
   endtask

   initial begin
      logic          hs_h1, hs_h2, vs_h1, vs_h2;
      logic [15:0]   w;
      logic [AW-1:0] exp_base, exp_adr;
      int            odd, pred, u, d, wcnt, acc;
      bit            skip;

      for (int i = 0; i < 16384; i++) fb_mem[i] = 16'($urandom);
      fb_mem[14'h1000] = 16'hA5F0;
      for (int b = 0; b < 2; b++)
         for (int j = 0; j < WPL; j++) begin
            bank_m[b][j] = 16'd0;
            bank_v[b][j] = 1'b0;
         end

      lines[0]  = mk(0, 0, 0,  0, 1, 0, 23'h1000);
      lines[1]  = mk(1, 0, 0,  0, 0, 0, 23'h0);
      lines[2]  = mk(1, 1, 0,  0, 0, 0, 23'h0);
      lines[3]  = mk(1, 1, 20, 0, 0, 0, 23'h0);
      lines[4]  = mk(1, 1, $urandom_range(0, 3), 0, 0, 0, 23'h0);
      lines[5]  = mk(1, 1, 0,  1, 0, 0, 23'h2000);
      lines[6]  = mk(1, 1, $urandom_range(0, 3), 0, 0, 0, 23'h0);
      lines[7]  = mk(0, 1, 0,  0, 0, 0, 23'h0);
      lines[8]  = mk(1, 0, 2,  0, 0, 1, 23'h0);
      lines[9]  = mk(1, 0, 0,  0, 0, 0, 23'h0);
      lines[10] = mk(1, 1, $urandom_range(0, 3), 0, 0, 0, 23'h0);
      lines[11] = mk(0, 1, 0,  0, 0, 0, 23'h0);

      rst_n = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; vfen_i = 1'b0; vren_i = 1'b0;
      odd_i = 1'b0; fb_base_i = '0; ack_i = 1'b0; dat_i = 16'd0;
      hs_h1 = 1'b0; hs_h2 = 1'b0; vs_h1 = 1'b0; vs_h2 = 1'b0;
      m_base = '0; wcnt = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;

      for (int l = 0; l < N_LINES; l++) begin
         odd = l % 2;
         if (lines[l].vs_start) begin
            fb_base_i = lines[l].fb;
            m_base    = lines[l].fb;
         end
         exp_base = m_base;
         acc = 0;
         u = 0;
         for (int j = 0; j < WPL; j++) begin
            disp_w[j] = bank_m[1-odd][j];
            disp_v[j] = bank_v[1-odd][j];
         end

         for (int x = 0; x < LINE_LEN; x++) begin
            @(negedge clk);
            skip = lines[l].rst && x >= 100 && x <= 654;
            if (!skip) begin
               check_val("hsync_dly", hsync_o, hs_h2);
               check_val("vsync_dly", vsync_o, vs_h2);
               d = x - 2;
               if (lines[l].vis && d >= 0 && d < 640) begin
                  if (disp_v[d/16]) begin
                     w = disp_w[d/16];
                     check_val($sformatf("video_l%0d_d%0d", l, d), video_o, w[15-(d%16)]);
                  end
               end else begin
                  check_val("video_blank", video_o, 1'b0);
               end
            end
            if (underrun_o === 1'b1) u++;
            hs_h2 = hs_h1;
            vs_h2 = vs_h1;

            vfen_i  = lines[l].fetch && x < 640;
            vren_i  = lines[l].vis && x < 640;
            hsync_i = x >= 660 && x < 680;
            vsync_i = (lines[l].vs_start && x < 20) || (lines[l].vs_blank && x >= 680 && x < 700);
            if (lines[l].vs_blank && x == 670) fb_base_i = lines[l].fb;
            if (x == 700) odd_i = 1'((l + 1) % 2);
            hs_h1 = hsync_i;
            vs_h1 = vsync_i;

            // Wishbone slave with a fixed number of wait states per word
            if (stb_o === 1'b1) begin
               if (wcnt >= lines[l].wt) begin
                  ack_i = 1'b1;
                  dat_i = fb_mem[adr_o[13:0]];
                  wcnt  = 0;
                  if (vfen_i) begin
                     exp_adr = exp_base + AW'(acc);
                     check_val("bus_addr", 32'(adr_o), 32'(exp_adr));
                     acc++;
                  end
               end else begin
                  ack_i = 1'b0;
                  dat_i = 16'($urandom);
                  wcnt++;
               end
            end else begin
               ack_i = ($urandom_range(0, 3) == 0);
               dat_i = 16'($urandom);
               wcnt  = 0;
            end

            if (lines[l].rst && x == 100) begin
               #5;
               rst_n = 1'b0;
               #1;
               check_reset_outputs("async_rst");
            end
            if (lines[l].rst && x == 650) rst_n = 1'b1;
         end

         pred = 639 / (lines[l].wt + 1);
         if (pred > WPL) pred = WPL;
         if (!lines[l].rst) begin
            check_val($sformatf("words_l%0d", l), acc, lines[l].fetch ? pred : 0);
            check_val($sformatf("underrun_l%0d", l), u, (lines[l].fetch && pred < WPL) ? 1 : 0);
         end else begin
            check_val($sformatf("underrun_rst_l%0d", l), u, 0);
         end

         if (lines[l].rst) begin
            m_base = '0;
            for (int j = 0; j < WPL; j++) bank_v[odd][j] = 1'b0;
         end else if (lines[l].fetch) begin
            for (int k = 0; k < pred; k++) begin
               exp_adr = exp_base + AW'(k);
               bank_m[odd][k] = fb_mem[exp_adr[13:0]];
               bank_v[odd][k] = 1'b1;
            end
            m_base = m_base + AW'(WPL);
         end
         if (lines[l].vs_blank) m_base = lines[l].fb;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
